keypad_entry_buffer: RTL and testbench

Keypad digit-entry front end: converts a 10-key one-hot keypad into a BCD digit plus key-valid strobe, routes each keypress to one of two channels (UI or SP), and stores successive digits into per-channel eight-slot 4-bit register files. It sits between the raw keypad inputs and the downstream display/compare logic, which read both digit files in parallel.

---
 rtl/keypad_pkg.sv | 21 ++
 rtl/digit_slot_file.sv | 52 +++++
 rtl/keypad_entry_buffer.sv | 114 +++++++++++
 tb/tb_keypad_entry_buffer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants and types for the keypad digit-entry front end.
// Optional multi-key rejection is enabled with KEYPAD_MULTIKEY_CHECK_EN.
package keypad_pkg;

  localparam int DIGIT_W   = 4;
  localparam int NUM_SLOTS = 8;
  localparam int PTR_W     = $clog2(NUM_SLOTS);
  localparam int NUM_KEYS  = 10;

  // Channel indices; also the bit positions inside mode_strobe.
  localparam logic CH_UI = 1'b0;
  localparam logic CH_SP = 1'b1;

  typedef logic [DIGIT_W-1:0] slot_array_t [NUM_SLOTS];

  // True when two or more keypad lines are asserted at once.
  function automatic logic is_multi_hot(input logic [NUM_KEYS-1:0] k);
    return (k & (k - 10'd1)) != 10'd0;
  endfunction

endpackage

// File: rtl/digit_slot_file.sv
// One channel's digit store: write pointer, eight-slot register file and
// sticky full flag. Writes land at the pointer, which then wraps around.
import keypad_pkg::*;

module digit_slot_file (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [DIGIT_W-1:0]             wr_data,
  output logic [NUM_SLOTS*DIGIT_W-1:0]   digits,
  output logic [PTR_W-1:0]               ptr,
  output logic                           full
);

  slot_array_t      slots_r;
  logic [PTR_W-1:0] ptr_r;
  logic             full_r;

  // Store the digit at the pointer, advance it, and latch full on the last slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        slots_r[k] <= {DIGIT_W{1'b0}};
      end
      ptr_r  <= {PTR_W{1'b0}};
      full_r <= 1'b0;
    end else if (wr_en) begin
      slots_r[ptr_r] <= wr_data;
      ptr_r          <= ptr_r + PTR_W'(1);
      if (ptr_r == PTR_W'(NUM_SLOTS - 1)) begin
        full_r <= 1'b1;
      end else begin
        full_r <= full_r;
      end
    end else begin
      ptr_r  <= ptr_r;
      full_r <= full_r;
    end
  end

  // Flatten the slot array so slot k occupies bits [DIGIT_W*k +: DIGIT_W].
  always_comb begin
    digits = {(NUM_SLOTS*DIGIT_W){1'b0}};
    for (int k = 0; k < NUM_SLOTS; k++) begin
      digits[k*DIGIT_W +: DIGIT_W] = slots_r[k];
    end
  end

  assign ptr  = ptr_r;
  assign full = full_r;

endmodule

// File: rtl/keypad_entry_buffer.sv
// Keypad entry front end: one-hot to BCD encoder, press edge detect, channel
// demux, and two digit slot files (UI and SP). Define KEYPAD_MULTIKEY_CHECK_EN
// to reject multi-key input and expose the registered key_err output.
import keypad_pkg::*;

module keypad_entry_buffer #(
  parameter int NUM_SLOTS = keypad_pkg::NUM_SLOTS,
  parameter int DIGIT_W   = keypad_pkg::DIGIT_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [9:0]                     key,
  input  logic                           sel,
  output logic [DIGIT_W-1:0]             bcd,
  output logic                           key_valid,
  output logic [1:0]                     mode_strobe,
  output logic [NUM_SLOTS*DIGIT_W-1:0]   ui_digits,
  output logic [NUM_SLOTS*DIGIT_W-1:0]   sp_digits,
  output logic [$clog2(NUM_SLOTS)-1:0]   ui_ptr,
  output logic [$clog2(NUM_SLOTS)-1:0]   sp_ptr,
  output logic                           ui_full,
  output logic                           sp_full
`ifdef KEYPAD_MULTIKEY_CHECK_EN
  ,
  output logic                           key_err
`endif
);

  logic [DIGIT_W-1:0] bcd_s;
  logic               valid_s;
  logic               multi_s;
  logic               press_s;
  logic               ui_wr_s;
  logic               sp_wr_s;
  logic               valid_q_r;
  logic [1:0]         mode_strobe_r;

  // Highest-index priority encode; optionally squash multi-hot input to "no key".
  always_comb begin
    bcd_s   = {DIGIT_W{1'b0}};
    valid_s = |key;
    multi_s = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      bcd_s = key[i] ? DIGIT_W'(i) : bcd_s;
    end
`ifdef KEYPAD_MULTIKEY_CHECK_EN
    multi_s = is_multi_hot(key);
`endif
    if (multi_s) begin
      bcd_s   = {DIGIT_W{1'b0}};
      valid_s = 1'b0;
    end else begin
      bcd_s   = bcd_s;
      valid_s = valid_s;
    end
  end

  assign bcd       = bcd_s;
  assign key_valid = valid_s;

  // A press is a rising edge of key_valid; route it to the selected channel.
  assign press_s = valid_s & ~valid_q_r;
  assign ui_wr_s = press_s & (sel == CH_UI);
  assign sp_wr_s = press_s & (sel == CH_SP);

  // Remember last cycle's key_valid and emit the one-cycle write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q_r     <= 1'b0;
      mode_strobe_r <= 2'b00;
    end else begin
      valid_q_r     <= valid_s;
      mode_strobe_r <= {sp_wr_s, ui_wr_s};
    end
  end

  assign mode_strobe = mode_strobe_r;

`ifdef KEYPAD_MULTIKEY_CHECK_EN
  logic key_err_r;

  // Registered multi-key error level, follows key with one cycle of delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_err_r <= 1'b0;
    end else begin
      key_err_r <= multi_s;
    end
  end

  assign key_err = key_err_r;
`endif

  digit_slot_file u_ui_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ui_wr_s),
    .wr_data (bcd_s),
    .digits  (ui_digits),
    .ptr     (ui_ptr),
    .full    (ui_full)
  );

  digit_slot_file u_sp_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (sp_wr_s),
    .wr_data (bcd_s),
    .digits  (sp_digits),
    .ptr     (sp_ptr),
    .full    (sp_full)
  );

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Self-checking bench for keypad_entry_buffer: encoder table, entry table
// with a write scoreboard, and hand sequences for hold/reset/multi-key cases.
module tb_keypad_entry_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  key;
  logic        sel;
  logic [3:0]  bcd;
  logic        key_valid;
  logic [1:0]  mode_strobe;
  logic [31:0] ui_digits;
  logic [31:0] sp_digits;
  logic [2:0]  ui_ptr;
  logic [2:0]  sp_ptr;
  logic        ui_full;
  logic        sp_full;
`ifdef KEYPAD_MULTIKEY_CHECK_EN
  logic        key_err;
`endif

  keypad_entry_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key         (key),
    .sel         (sel),
    .bcd         (bcd),
    .key_valid   (key_valid),
    .mode_strobe (mode_strobe),
    .ui_digits   (ui_digits),
    .sp_digits   (sp_digits),
    .ui_ptr      (ui_ptr),
    .sp_ptr      (sp_ptr),
    .ui_full     (ui_full),
    .sp_full     (sp_full)
`ifdef KEYPAD_MULTIKEY_CHECK_EN
    ,
    .key_err     (key_err)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       ch;
    logic [2:0] slot;
    logic [3:0] val;
    logic [2:0] ptr;
    logic       full;
  } exp_t;

  typedef struct {
    logic [9:0] key;
    logic [3:0] bcd;
    logic       valid;
  } enc_vec_t;

  typedef struct {
    int         d;
    logic       s;
    int         hold;
    logic [2:0] ptr;
    logic       full;
  } ent_vec_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [3:0] ui_m[8];
  logic [3:0] sp_m[8];
  int         ui_pm;
  int         sp_pm;
  enc_vec_t   enc_tbl[8];
  ent_vec_t   ent_tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] pack(input logic [3:0] m[8]);
    logic [31:0] r;
    r = 32'd0;
    for (int k = 0; k < 8; k++) r[k*4 +: 4] = m[k];
    return r;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 8; k++) begin
      ui_m[k] = 4'd0;
      sp_m[k] = 4'd0;
    end
    ui_pm = 0;
    sp_pm = 0;
  endtask

  // Record an expected write on channel s and advance the reference model.
  task automatic expect_write(input int d, input logic s, input logic [2:0] eptr, input logic efull);
    exp_t e;
    e.ch   = s;
    e.val  = 4'(d);
    e.ptr  = eptr;
    e.full = efull;
    if (s) begin
      e.slot = 3'(sp_pm);
      sp_m[sp_pm] = 4'(d);
      sp_pm = (sp_pm + 1) % 8;
    end else begin
      e.slot = 3'(ui_pm);
      ui_m[ui_pm] = 4'(d);
      ui_pm = (ui_pm + 1) % 8;
    end
    sb_q.push_back(e);
  endtask

  task automatic press(input int d, input logic s, input int hold, input logic [2:0] eptr, input logic efull);
    @(negedge clk);
    key = 10'd1 << d;
    sel = s;
    #1;
    chk("press_bcd", {28'd0, bcd}, 32'(d));
    chk("press_valid", {31'd0, key_valid}, 32'd1);
    expect_write(d, s, eptr, efull);
    repeat (hold) @(negedge clk);
    key = 10'd0;
    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
  endtask

  // Scoreboard consumer: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mode_strobe !== 2'b00) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_strobe", {30'd0, mode_strobe}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("strobe", {30'd0, mode_strobe}, mon_e.ch ? 32'd2 : 32'd1);
        if (mon_e.ch) begin
          chk("sp_slot", {28'd0, sp_digits[mon_e.slot*4 +: 4]}, {28'd0, mon_e.val});
          chk("sp_ptr", {29'd0, sp_ptr}, {29'd0, mon_e.ptr});
          chk("sp_full", {31'd0, sp_full}, {31'd0, mon_e.full});
        end else begin
          chk("ui_slot", {28'd0, ui_digits[mon_e.slot*4 +: 4]}, {28'd0, mon_e.val});
          chk("ui_ptr", {29'd0, ui_ptr}, {29'd0, mon_e.ptr});
          chk("ui_full", {31'd0, ui_full}, {31'd0, mon_e.full});
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ui_digits"}, ui_digits, 32'd0);
    chk({tag, "_sp_digits"}, sp_digits, 32'd0);
    chk({tag, "_ptrs"}, {26'd0, ui_ptr, sp_ptr}, 32'd0);
    chk({tag, "_fulls"}, {30'd0, ui_full, sp_full}, 32'd0);
    chk({tag, "_strobe"}, {30'd0, mode_strobe}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    key   = 10'd0;
    sel   = 1'b0;
    clear_model();

    enc_tbl[0] = '{10'h000, 4'd0, 1'b0};
    enc_tbl[1] = '{10'h001, 4'd0, 1'b1};
    enc_tbl[2] = '{10'h002, 4'd1, 1'b1};
    enc_tbl[3] = '{10'h004, 4'd2, 1'b1};
    enc_tbl[4] = '{10'h080, 4'd7, 1'b1};
    enc_tbl[5] = '{10'h200, 4'd9, 1'b1};
`ifdef KEYPAD_MULTIKEY_CHECK_EN
    enc_tbl[6] = '{10'h030, 4'd0, 1'b0};
    enc_tbl[7] = '{10'h201, 4'd0, 1'b0};
`else
    enc_tbl[6] = '{10'h030, 4'd5, 1'b1};
    enc_tbl[7] = '{10'h201, 4'd9, 1'b1};
`endif

    ent_tbl[0] = '{2, 1'b1, 5,  3'd1, 1'b0};
    ent_tbl[1] = '{1, 1'b1, 5,  3'd2, 1'b0};
    ent_tbl[2] = '{9, 1'b1, 5,  3'd3, 1'b0};
    ent_tbl[3] = '{3, 1'b1, 5,  3'd4, 1'b0};
    ent_tbl[4] = '{5, 1'b1, 5,  3'd5, 1'b0};
    ent_tbl[5] = '{4, 1'b1, 5,  3'd6, 1'b0};
    ent_tbl[6] = '{8, 1'b1, 5,  3'd7, 1'b0};
    ent_tbl[7] = '{8, 1'b1, 5,  3'd0, 1'b1};
    ent_tbl[8] = '{1, 1'b1, 5,  3'd1, 1'b1};
    ent_tbl[9] = '{7, 1'b0, 10, 3'd1, 1'b0};

    // Encoder is combinational, so exercise it while held in reset (no writes).
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      key = enc_tbl[i].key;
      #1;
      chk("enc_bcd", {28'd0, bcd}, {28'd0, enc_tbl[i].bcd});
      chk("enc_valid", {31'd0, key_valid}, {31'd0, enc_tbl[i].valid});
    end
    key = 10'd0;

    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_bcd", {27'd0, key_valid, bcd}, 32'd0);

    // Entry table: fill SP past wrap, then a held UI key.
    for (int i = 0; i < 10; i++) begin
      press(ent_tbl[i].d, ent_tbl[i].s, ent_tbl[i].hold, ent_tbl[i].ptr, ent_tbl[i].full);
    end
    chk("sp_image", sp_digits, 32'h8845_3911);
    chk("sp_model", sp_digits, pack(sp_m));
    chk("ui_image", ui_digits, 32'h0000_0007);
    chk("ptr_flags", {24'd0, ui_ptr, sp_ptr, ui_full, sp_full}, {24'd0, 3'd1, 3'd1, 1'b0, 1'b1});

    // Held key: toggling sel and changing key without release writes nothing more.
    @(negedge clk);
    key = 10'd1 << 5;
    sel = 1'b0;
    expect_write(5, 1'b0, 3'd2, 1'b0);
    repeat (2) @(negedge clk);
    sel = 1'b1;
    repeat (2) @(negedge clk);
    key = 10'd1 << 6;
    repeat (3) @(negedge clk);
    sel = 1'b0;
    repeat (2) @(negedge clk);
    key = 10'd0;
    repeat (3) @(negedge clk);
    chk("held_drain", 32'(sb_q.size()), 32'd0);
    chk("held_ui", ui_digits, pack(ui_m));
    chk("held_sp", sp_digits, 32'h8845_3911);

    // Reset asserted mid-press clears everything asynchronously.
    @(negedge clk);
    key = 10'd1 << 3;
    sel = 1'b0;
    expect_write(3, 1'b0, 3'd3, 1'b0);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    clear_model();
    key = 10'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    press(6, 1'b0, 5, 3'd1, 1'b0);
    chk("post_rst_ui", ui_digits, 32'h0000_0006);

    // Key held through reset release produces one event once valid_q is clear.
    @(negedge clk);
    rst_n = 1'b0;
    key = 10'd1 << 4;
    sel = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_write(4, 1'b0, 3'd1, 1'b0);
    repeat (4) @(negedge clk);
    key = 10'd0;
    repeat (3) @(negedge clk);
    chk("held_rst_drain", 32'(sb_q.size()), 32'd0);
    chk("held_rst_ui", ui_digits, 32'h0000_0004);

`ifdef KEYPAD_MULTIKEY_CHECK_EN
    // Two keys together: no valid, error flag one cycle later, no write.
    @(negedge clk);
    key = 10'h030;
    #1;
    chk("multi_valid", {31'd0, key_valid}, 32'd0);
    chk("multi_bcd", {28'd0, bcd}, 32'd0);
    @(negedge clk);
    chk("multi_err_set", {31'd0, key_err}, 32'd1);
    key = 10'd0;
    @(negedge clk);
    chk("multi_err_clr", {31'd0, key_err}, 32'd0);
    repeat (2) @(negedge clk);
    chk("multi_no_write", ui_digits, 32'h0000_0004);
`endif

    chk("sb_final", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
